// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Issue stage between fetch and ID for the 5-stage, 20-bit-instruction
//   pipeline. It tracks pending register writes, stalls fetch on a read of
//   an unwritten operand, and issues flush bubbles after a taken branch.
//
// Ports
//   clkwire      in   1   clock, all state updates on posedge
//   rstwire      in   1   synchronous active-high reset
//   fetch_instr  in   20  instruction presented by fetch
//   fetch_valid  in   1   fetch_instr is real; 0 = issue a bubble
//   br_taken     in   1   1-cycle pulse from EX, branch resolved taken
//   issue_instr  out  20  registered instruction to ID
//   pc_hold      out  1   combinational: fetch must hold PC/instr this cycle
//   flushing     out  1   registered: issue_instr is a flush bubble
//   stall_count  out  16  saturating count of stall bubbles issued
//
// Issue modes, highest priority first:
//   mode      | meaning
//   flush     | flush counter nonzero: issue E0000, drop fetch_instr
//   branch    | br_taken: issue E0000, load flush counter FLUSH_SLOTS-1
//   stall     | operand pending: issue F0000, hold fetch, count the stall
//   bubble    | fetch_valid=0: issue F0000
//   issue     | pass fetch_instr, load scoreboard for its destination
module hazard_scheduler #(
  parameter int unsigned WB_DIST     = 3,
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic        clkwire,
  input  logic        rstwire,
  input  logic [19:0] fetch_instr,
  input  logic        fetch_valid,
  input  logic        br_taken,
  output logic [19:0] issue_instr,
  output logic        pc_hold,
  output logic        flushing,
  output logic [15:0] stall_count
);

  localparam logic [2:0]  WB_LOAD    = 3'(WB_DIST);
  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_SLOTS - 1);
  localparam logic [19:0] STALL_BUB  = 20'hF0000;
  localparam logic [19:0] FLUSH_BUB  = 20'hE0000;

  logic [2:0] cnt [8];
  logic [2:0] flush_cnt;

  logic [3:0] opcode;
  logic [3:0] fld_a, fld_b, fld_c;
  logic       dest_v, src_a_v, src_b_v;
  logic [2:0] dest, src_a, src_b;
  logic       hazard;
  logic       flush_now;

  assign opcode = fetch_instr[19:16];
  assign fld_a  = fetch_instr[15:12];
  assign fld_b  = fetch_instr[11:8];
  assign fld_c  = fetch_instr[7:4];

  // A field value of 8 or above names no register, so bit 3 gates validity.
  always_comb begin
    dest_v  = 1'b0;
    dest    = 3'd0;
    src_a_v = 1'b0;
    src_a   = 3'd0;
    src_b_v = 1'b0;
    src_b   = 3'd0;
    case (opcode)
      4'h0, 4'h1, 4'h2: begin
        dest_v  = ~fld_a[3];
        dest    = fld_a[2:0];
        src_a_v = ~fld_b[3];
        src_a   = fld_b[2:0];
        src_b_v = ~fld_c[3];
        src_b   = fld_c[2:0];
      end
      4'h3: begin
        dest_v = ~fld_a[3];
        dest   = fld_a[2:0];
      end
      4'h4: begin
        src_a_v = ~fld_a[3];
        src_a   = fld_a[2:0];
      end
      4'h5, 4'h6: begin
        src_a_v = ~fld_a[3];
        src_a   = fld_a[2:0];
        src_b_v = ~fld_b[3];
        src_b   = fld_b[2:0];
      end
      default: ;
    endcase
  end

  assign hazard    = fetch_valid &
                     ((src_a_v & (cnt[src_a] != 3'd0)) |
                      (src_b_v & (cnt[src_b] != 3'd0)));
  assign flush_now = (flush_cnt != 3'd0) | br_taken;
  assign pc_hold   = ~rstwire & ~flush_now & hazard;

  always_ff @(posedge clkwire) begin
    if (rstwire) begin
      issue_instr <= STALL_BUB;
      flushing    <= 1'b0;
      stall_count <= 16'd0;
      flush_cnt   <= 3'd0;
      for (int i = 0; i < 8; i++) cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
      end

      // A branch during an active flush restarts the window.
      if (br_taken)
        flush_cnt <= FLUSH_LOAD;
      else if (flush_cnt != 3'd0)
        flush_cnt <= flush_cnt - 3'd1;

      flushing <= flush_now;

      if (flush_now) begin
        issue_instr <= FLUSH_BUB;
      end else if (hazard) begin
        issue_instr <= STALL_BUB;
        if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      end else if (!fetch_valid) begin
        issue_instr <= STALL_BUB;
      end else begin
        issue_instr <= fetch_instr;
        // Placed after the decrement loop so a load wins on the same register.
        if (dest_v) cnt[dest] <= WB_LOAD;
      end
    end
  end

endmodule
